// File: rtl/input_conditioner_if.sv
// input_conditioner_if
//   Bundles the pin bank, filter configuration and conditioned outputs of the
//   timer/counter input front-end.
//   master : the controlling side (drives pins/config, observes outputs)
//   slave  : the input_conditioner itself
//   pins_i       raw asynchronous pin levels
//   enable_i     filter enable (0 freezes filter state)
//   in_sel_i     pin index; out-of-range index selects constant 0
//   invert_i     invert the selected pin before filtering
//   filt_len_i   qualification length L (0 = bypass)
//   clear_i      synchronous clear of the glitch counter
//   selected_o   filtered level
//   rise_o       one-cycle pulse on a 0->1 transition of selected_o
//   fall_o       one-cycle pulse on a 1->0 transition of selected_o
//   glitch_cnt_o count of rejected pulses
interface input_conditioner_if #(
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = 2,
  parameter int FILT_W     = 8
);
  logic [NUM_INPUTS-1:0] pins_i;
  logic                  enable_i;
  logic [SEL_W-1:0]      in_sel_i;
  logic                  invert_i;
  logic [FILT_W-1:0]     filt_len_i;
  logic                  clear_i;
  logic                  selected_o;
  logic                  rise_o;
  logic                  fall_o;
  logic [15:0]           glitch_cnt_o;

  modport master (
    output pins_i, enable_i, in_sel_i, invert_i, filt_len_i, clear_i,
    input  selected_o, rise_o, fall_o, glitch_cnt_o
  );

  modport slave (
    input  pins_i, enable_i, in_sel_i, invert_i, filt_len_i, clear_i,
    output selected_o, rise_o, fall_o, glitch_cnt_o
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner
//   Input front-end for the timer/counter channel: 2-flop synchronises every
//   pin, selects one, optionally inverts it, and runs it through a
//   programmable-length glitch filter. All outputs are registered.
//
//   Ports:
//     clk_i  system clock, rising edge
//     rst_i  asynchronous active-high reset
//     bus    input_conditioner_if.slave (pins, config, filtered outputs)
//
//   Optional feature macro: INCOND_GLITCH_CNT_EN
//     defined   : 16-bit saturating count of rejected pulses, cleared by clear_i
//     undefined : glitch_cnt_o tied to 0, clear_i ignored
//
//   Filter states:
//     state     | meaning
//     ----------+---------------------------------------------------------
//     ST_STABLE | raw agrees with filt_q (or just resolved); cnt = 0
//     ST_QUAL   | raw differs from filt_q; cnt = samples seen so far
module input_conditioner #(
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = 2,
  parameter int FILT_W     = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  input_conditioner_if.slave bus
);

  // Pad the synchroniser bank up to the full select range so any index
  // beyond the real pins reads constant 0.
  localparam int PAD_W = ((2 ** SEL_W) > NUM_INPUTS) ? (2 ** SEL_W) : NUM_INPUTS;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } state_t;

  logic [NUM_INPUTS-1:0] sync1_q;
  logic [NUM_INPUTS-1:0] sync2_q;
  logic [PAD_W-1:0]      sync_pad;
  logic                  raw;

  state_t                state_q;
  logic [FILT_W-1:0]     cnt_q;
  logic                  filt_q;
  logic                  rise_q;
  logic                  fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.pins_i;
      sync2_q <= sync1_q;
    end
  end

  assign sync_pad = PAD_W'(sync2_q);
  assign raw      = sync_pad[bus.in_sel_i] ^ bus.invert_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!bus.enable_i) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
      end else if (bus.filt_len_i == '0) begin
        // Bypass wins even over an in-flight qualification.
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        filt_q  <= raw;
        rise_q  <= raw & ~filt_q;
        fall_q  <= ~raw & filt_q;
      end else begin
        case (state_q)
          ST_STABLE: begin
            if (raw != filt_q) begin
              state_q <= ST_QUAL;
              cnt_q   <= FILT_W'(1);
            end
          end
          ST_QUAL: begin
            if (raw == filt_q) begin
              state_q <= ST_STABLE;
              cnt_q   <= '0;
            end else if (cnt_q >= bus.filt_len_i) begin
              // >= so that shrinking L mid-run completes on the next edge.
              filt_q  <= raw;
              rise_q  <= raw;
              fall_q  <= ~raw;
              state_q <= ST_STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + FILT_W'(1);
            end
          end
          default: begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.selected_o = filt_q;
  assign bus.rise_o     = rise_q;
  assign bus.fall_o     = fall_q;

`ifdef INCOND_GLITCH_CNT_EN
  logic        glitch_evt;
  logic [15:0] glitch_cnt_q;

  // A rejected pulse: qualification in progress and raw fell back to filt_q.
  assign glitch_evt = bus.enable_i && (bus.filt_len_i != '0) &&
                      (state_q == ST_QUAL) && (raw == filt_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      glitch_cnt_q <= '0;
    end else if (bus.clear_i) begin
      glitch_cnt_q <= '0;
    end else if (glitch_evt && (glitch_cnt_q != 16'hFFFF)) begin
      glitch_cnt_q <= glitch_cnt_q + 16'd1;
    end
  end

  assign bus.glitch_cnt_o = glitch_cnt_q;
`else
  logic unused_clear;
  assign unused_clear     = bus.clear_i;
  assign bus.glitch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
  localparam int NI = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  input_conditioner_if #(.NUM_INPUTS(NI), .SEL_W(2), .FILT_W(8)) ifc ();

  input_conditioner #(.NUM_INPUTS(NI), .SEL_W(2), .FILT_W(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifc.slave)
  );

  // Reference model: the filter as a run-length rule -- a new level is
  // accepted once raw has disagreed with it for L+1 consecutive samples;
  // a disagreement run that ends early is a glitch.
  logic [NI-1:0] m_s1, m_s2;
  logic          m_raw, m_level, m_rise, m_fall, m_glitch;
  int            m_run;
  logic [15:0]   m_gcnt;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_s1 = '0; m_s2 = '0; m_level = 1'b0; m_run = 0;
      m_rise = 1'b0; m_fall = 1'b0; m_gcnt = '0;
    end else begin
      m_raw = ((int'(ifc.in_sel_i) < NI) ? m_s2[ifc.in_sel_i] : 1'b0) ^ ifc.invert_i;
      m_s2 = m_s1;
      m_s1 = ifc.pins_i;
      m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
      if (!ifc.enable_i) begin
        m_run = 0;
      end else if (ifc.filt_len_i == 0) begin
        if (m_raw != m_level) begin
          m_rise = m_raw; m_fall = !m_raw; m_level = m_raw;
        end
        m_run = 0;
      end else if (m_raw != m_level) begin
        m_run++;
        if (m_run >= int'(ifc.filt_len_i) + 1) begin
          m_rise = m_raw; m_fall = !m_raw; m_level = m_raw; m_run = 0;
        end
      end else begin
        m_glitch = (m_run > 0);
        m_run = 0;
      end
`ifdef INCOND_GLITCH_CNT_EN
      if (ifc.clear_i) m_gcnt = '0;
      else if (m_glitch && m_gcnt != 16'hFFFF) m_gcnt = m_gcnt + 16'd1;
`else
      m_gcnt = '0;
`endif
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reset with the given configuration; returns just after edge 0, the
  // last edge that still sees reset.
  task automatic do_reset(input logic [7:0] len, input logic [1:0] sel, input logic inv);
    rst_i          = 1'b1;
    ifc.pins_i     = '0;
    ifc.enable_i   = 1'b1;
    ifc.in_sel_i   = sel;
    ifc.invert_i   = inv;
    ifc.filt_len_i = len;
    ifc.clear_i    = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #2;
    n_tests++;
    if ({ifc.selected_o, ifc.rise_o, ifc.fall_o, ifc.glitch_cnt_o} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: sel=%b rise=%b fall=%b gcnt=%h, want all 0",
               ifc.selected_o, ifc.rise_o, ifc.fall_o, ifc.glitch_cnt_o);
    end
  endtask

  // L=3: pin set after edge 2 -> first sampling edge 3 -> new level at edge 3+2+3=8.
  task automatic test_qualify();
    do_reset(8'd3, 2'd2, 1'b0);
    tick(); tick();
    ifc.pins_i[2] = 1'b1;
    for (int e = 3; e <= 12; e++) begin
      tick();
      n_tests++;
      if (ifc.selected_o !== (e >= 8) || ifc.rise_o !== (e == 8) || ifc.fall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL qualify edge %0d: sel=%b rise=%b fall=%b, want sel=%b rise=%b fall=0",
                 e, ifc.selected_o, ifc.rise_o, ifc.fall_o, e >= 8, e == 8);
      end
    end
  endtask

  // L=3: pin high for 3 cycles gives only 3 raw samples, so it is rejected.
  task automatic test_glitch_reject();
    logic [15:0] want;
    do_reset(8'd3, 2'd2, 1'b0);
    tick(); tick();
    ifc.pins_i[2] = 1'b1;
    tick(); tick(); tick();
    ifc.pins_i[2] = 1'b0;
    for (int e = 6; e <= 14; e++) begin
      tick();
      n_tests++;
      if (ifc.selected_o !== 1'b0 || ifc.rise_o !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_reject edge %0d: sel=%b rise=%b, want 0 0",
                 e, ifc.selected_o, ifc.rise_o);
      end
    end
`ifdef INCOND_GLITCH_CNT_EN
    want = 16'd1;
`else
    want = 16'd0;
`endif
    n_tests++;
    if (ifc.glitch_cnt_o !== want) begin
      n_fail++;
      $display("FAIL glitch_reject_count: got %0d want %0d", ifc.glitch_cnt_o, want);
    end
  endtask

  // L=0: selected follows pin1 three edges after it is driven.
  task automatic test_bypass();
    logic hist [20];
    logic prev;
    int   n_rise, n_fall;
    do_reset(8'd0, 2'd1, 1'b0);
    prev = 1'b0; n_rise = 0; n_fall = 0;
    for (int n = 0; n < 20; n++) begin
      hist[n] = ((n / 2) % 2) == 1;
      ifc.pins_i[1] = hist[n];
      tick();
      if (n >= 2) begin
        n_tests++;
        if (ifc.selected_o !== hist[n-2] ||
            ifc.rise_o !== (hist[n-2] && !prev) || ifc.fall_o !== (!hist[n-2] && prev)) begin
          n_fail++;
          $display("FAIL bypass step %0d: sel=%b rise=%b fall=%b, want sel=%b",
                   n, ifc.selected_o, ifc.rise_o, ifc.fall_o, hist[n-2]);
        end
      end
      if (ifc.rise_o === 1'b1) n_rise++;
      if (ifc.fall_o === 1'b1) n_fall++;
      prev = ifc.selected_o;
    end
    n_tests++;
    if (n_rise != 4 || n_fall != 4 || ifc.glitch_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL bypass_counts: rises=%0d falls=%0d gcnt=%0d, want 4 4 0",
               n_rise, n_fall, ifc.glitch_cnt_o);
    end
  endtask

  // Invert with all pins low: raw is 1 straight out of reset, so the filter
  // sees L+1 = 3 disagreeing samples at edges 1..3 and rises at edge 3.
  task automatic test_invert_after_reset();
    do_reset(8'd2, 2'd0, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_tests++;
      if (ifc.selected_o !== (e >= 3) || ifc.rise_o !== (e == 3)) begin
        n_fail++;
        $display("FAIL invert edge %0d: sel=%b rise=%b, want sel=%b rise=%b",
                 e, ifc.selected_o, ifc.rise_o, e >= 3, e == 3);
      end
    end
  endtask

  // L=5: qualification starts at edge 4, disabled for edges 6..9 (cnt was 2),
  // re-enabled at edge 10 -> restarts and completes at edge 15.
  task automatic test_enable_pause();
    do_reset(8'd5, 2'd0, 1'b0);
    tick();
    ifc.pins_i[0] = 1'b1;
    for (int e = 2; e <= 18; e++) begin
      tick();
      if (e == 5) ifc.enable_i = 1'b0;
      if (e == 9) ifc.enable_i = 1'b1;
      n_tests++;
      if (ifc.selected_o !== (e >= 15) || ifc.rise_o !== (e == 15) || ifc.fall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_pause edge %0d: sel=%b rise=%b fall=%b, want sel=%b rise=%b",
                 e, ifc.selected_o, ifc.rise_o, ifc.fall_o, e >= 15, e == 15);
      end
    end
  endtask

  task automatic test_random();
    do_reset(8'd2, 2'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ifc.pins_i = NI'($urandom());
      if ($urandom_range(0, 31) == 0) ifc.in_sel_i = 2'($urandom());
      if ($urandom_range(0, 31) == 0) ifc.invert_i = 1'($urandom());
      if ($urandom_range(0, 15) == 0) ifc.filt_len_i = 8'($urandom_range(0, 4));
      ifc.enable_i = ($urandom_range(0, 15) != 0);
      ifc.clear_i  = ($urandom_range(0, 63) == 0);
      tick();
      n_tests++;
      if (ifc.selected_o !== m_level || ifc.rise_o !== m_rise || ifc.fall_o !== m_fall ||
          ifc.glitch_cnt_o !== m_gcnt) begin
        n_fail++;
        $display("FAIL random cycle %0d: sel/rise/fall/gcnt=%b/%b/%b/%h, want %b/%b/%b/%h",
                 i, ifc.selected_o, ifc.rise_o, ifc.fall_o, ifc.glitch_cnt_o,
                 m_level, m_rise, m_fall, m_gcnt);
      end
    end
    ifc.clear_i = 1'b0;
    ifc.enable_i = 1'b1;
  endtask

`ifdef INCOND_GLITCH_CNT_EN
  // L=2: a 1-cycle pin pulse after edge e0 is rejected at edge e0+4.
  task automatic test_saturation();
    do_reset(8'd2, 2'd0, 1'b0);
    tick();
    force dut.glitch_cnt_q = 16'hFFFF;
    m_gcnt = 16'hFFFF;
    tick();
    release dut.glitch_cnt_q;
    ifc.pins_i[0] = 1'b1;
    tick();
    ifc.pins_i[0] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_tests++;
    if (ifc.glitch_cnt_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturate: gcnt=%h want FFFF", ifc.glitch_cnt_o);
    end
    ifc.pins_i[0] = 1'b1;
    tick();
    ifc.pins_i[0] = 1'b0;
    tick(); tick();
    ifc.clear_i = 1'b1;
    tick();
    ifc.clear_i = 1'b0;
    n_tests++;
    if (ifc.glitch_cnt_o !== 16'h0000 || m_gcnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_wins: gcnt=%h model=%h want 0000", ifc.glitch_cnt_o, m_gcnt);
    end
  endtask
`endif

  initial begin
    ifc.pins_i = '0; ifc.enable_i = 1'b1; ifc.in_sel_i = '0;
    ifc.invert_i = 1'b0; ifc.filt_len_i = 8'd3; ifc.clear_i = 1'b0;
    test_reset();
    test_qualify();
    test_glitch_reject();
    test_bypass();
    test_invert_after_reset();
    test_enable_pause();
    test_random();
`ifdef INCOND_GLITCH_CNT_EN
    test_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
